// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the fetch-to-instruction-memory path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_fetch_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  // Instruction word returned with a faulting response.
  localparam logic [INSTR_W-1:0] FAULT_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Response payload held stable while waiting for the consumer.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               fault;
  } rsp_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch <-> instruction-memory request/response bundle.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
// Ports: req_valid/req_ready/req_pc, flush, rsp_valid/rsp_ready/rsp_instr/rsp_pc/rsp_fault.
interface imem_responder_if;
  import riscv_fetch_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [PC_W-1:0]    req_pc;
  logic               flush;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [INSTR_W-1:0] rsp_instr;
  logic [PC_W-1:0]    rsp_pc;
  logic               rsp_fault;

  // Fetch stage side.
  modport master (
    output req_valid, req_pc, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
  );

  // Instruction memory side.
  modport slave (
    input  req_valid, req_pc, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_fault
  );

endinterface

// File: rtl/imem_byte_array.sv
// Byte-addressed instruction store: one synchronous write port, four combinational read ports.
// Latency: write visible after the clock edge; reads are zero-latency.
// Backpressure: none, write and reads are always accepted.
// Ports: clk, wr_en/wr_addr/wr_data (loader), rd_addr[4]/rd_data[4].
module imem_byte_array #(
  parameter int ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [7:0]             wr_data,
  input  logic [3:0][ADDR_W-1:0] rd_addr,
  output logic [3:0][7:0]        rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  // Contents are not reset; software loads the program before fetching.
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Reads sample the array before any same-edge write lands (read-before-write).
  for (genvar i = 0; i < 4; i++) begin : g_rd
    assign rd_data[i] = mem_q[rd_addr[i]];
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one PC request in flight, returns a little-endian 32-bit word.
// Latency: rsp_valid rises LATENCY cycles after the accepting edge; LATENCY+1 cycles per request back-to-back.
// Backpressure: response held stable until rsp_ready; a new request is taken only in IDLE or on the draining edge.
// Ports: clk, rst_n, bus (imem_responder_if.slave), ld_en/ld_addr/ld_data (byte loader).
module imem_responder
  import riscv_fetch_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_responder_if.slave   bus,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data
);

  localparam logic [1:0] CNT_LOAD = 2'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  rsp_t                  rsp_q, rsp_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  req_rdy;
  logic                  req_acc;
  logic                  fault;
  logic [3:0][ADDR_W-1:0] rd_addr;
  logic [3:0][7:0]       rd_data;

  imem_byte_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Byte lanes of the word at the latched PC; wrap only matters for faulting
  // addresses, whose data is discarded anyway.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_addr[i] = pc_q[ADDR_W-1:0] + ADDR_W'(i);
    end
  end

  assign fault = (pc_q[1:0] != 2'b00) || (pc_q[PC_W-1:ADDR_W] != '0);

  // Ready also depends on rst_n so the fetch stage sees no ready during reset.
  assign req_rdy = rst_n && !bus.flush &&
                   ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));
  assign req_acc = bus.req_valid && req_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    rsp_d   = rsp_q;

    unique case (state_q)
      IDLE: begin
        if (req_acc) state_d = BUSY;
      end
      BUSY: begin
        if (cnt_q == 2'd0) begin
          state_d     = RESP;
          rsp_d.pc    = pc_q;
          rsp_d.fault = fault;
          rsp_d.instr = fault ? FAULT_INSTR : rd_data;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = req_acc ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (req_acc) begin
      pc_d  = bus.req_pc;
      cnt_d = CNT_LOAD;
    end

    // req_acc is already masked by flush, so only the state needs overriding.
    if (bus.flush) state_d = IDLE;
  end

  assign rsp_vld_d = (state_d == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      pc_q      <= '0;
      rsp_q     <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      rsp_q     <= rsp_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  assign bus.req_ready = req_rdy;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_instr = rsp_q.instr;
  assign bus.rsp_pc    = rsp_q.pc;
  assign bus.rsp_fault = rsp_q.fault;

endmodule

// File: doc/imem_responder.md
# imem_responder

Responder side of the fetch-to-instruction-memory interface. Accepts one 64-bit PC request at a time from the fetch stage, reads four bytes from a byte-addressed instruction store, and returns the little-endian 32-bit instruction after a fixed, parameterised latency. Supports response backpressure, branch flush, and a byte-wide loader port for programming the store. Sits between the fetch stage and decode, replacing the zero-latency combinational instruction memory.

## Interface
- ADDR_W, 16, byte-address width; store depth is 2^ADDR_W bytes
- LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..4

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch presents a request
- req_ready  out  1  responder can accept a request this cycle
- req_pc  in  64  byte address of the instruction
- flush  in  1  branch redirect; kills any in-flight request or response
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_instr  out  32  instruction word, byte[pc] in bits 7:0
- rsp_pc  out  64  PC of the returned instruction
- rsp_fault  out  1  request was misaligned or out of range
- ld_en  in  1  loader byte write strobe
- ld_addr  in  ADDR_W  loader byte address
- ld_data  in  8  loader byte

## Operation
- FSM states: IDLE, BUSY, RESP. Reset and flush force IDLE.
- req_ready = rst_n && !flush && (IDLE || (RESP && rsp_ready)).
- Accept when req_valid && req_ready: latch req_pc, load cnt = LATENCY-1, go to BUSY.
- BUSY: if cnt == 0, capture the response and go to RESP. Otherwise decrement cnt.
- Capture: fault = (req_pc[1:0] != 0) || (req_pc[63:ADDR_W] != 0). On fault, rsp_instr = 0. Otherwise rsp_instr = {mem[pc+3], mem[pc+2], mem[pc+1], mem[pc]}. rsp_pc = latched pc.
- Aligned, in-range addresses never wrap, so pc+3 <= 2^ADDR_W-1 always holds.
- RESP: rsp_valid = 1, and rsp_instr, rsp_pc and rsp_fault stay stable until rsp_ready.
- On rsp_ready with a simultaneous accepted request, go directly to BUSY; otherwise go to IDLE.
- flush in any state: next state is IDLE and rsp_valid drops after the edge. Flush wins over a same-cycle request, which is not accepted.
- Loader write is synchronous and independent of the FSM. A same-cycle write to a byte being captured returns the old byte (read-before-write).
- The store is not reset; contents are undefined until loaded.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_instr 0, rsp_pc 0, rsp_fault 0, cnt 0; req_ready 0 while rst_n is low.
- Request accepted at edge N gives rsp_valid = 1 after edge N+LATENCY.
- Back-to-back throughput is one response per LATENCY+1 cycles when rsp_ready is held high.
- rsp_valid is registered. req_ready is combinational from state, flush, rsp_ready and rst_n.
- rst_n asserted mid-operation drops rsp_valid immediately (asynchronous) and discards the request. After release, the first accept is legal at the first rising edge.

## Structure
- Package riscv_fetch_pkg:
  - state enum {IDLE, BUSY, RESP}
  - PC_W = 64
  - INSTR_W = 32
  - fault instruction constant 32'h0
- Sub-module imem_byte_array (parameter ADDR_W): one synchronous byte write port, four combinational byte read ports.
- imem_responder instantiates it and holds the FSM, counter and response registers.

## Test plan
- Load B3 04 5A 01 at 0x4; LATENCY=2; request pc 0x4 accepted at edge N -> after edge N+2: rsp_valid=1, rsp_instr=0x015A04B3, rsp_pc=0x4, rsp_fault=0.
- Request pc 0x6, then pc 0x10000 (ADDR_W=16) -> each response has rsp_fault=1 and rsp_instr=0x00000000.
- Hold rsp_ready low for 3 cycles in RESP -> outputs stable, req_ready=0; raise rsp_ready with req_valid at pc 0x8 -> handshake and re-entry to BUSY on the same edge.
- Assert flush in BUSY for pc 0x4 -> no response. Then request pc 0x8 (loaded 93 84 14 00) -> rsp_instr=0x00148493.
- flush and req_valid in the same IDLE cycle -> req_ready=0, no accept, no later rsp_valid.
- Deassert rst_n mid-BUSY -> rsp_valid=0 immediately. After release, request pc 0x4 completes normally with LATENCY=1 and LATENCY=4.
